game_flow_ctrl: RTL and testbench

Game-flow sequencer for the score counter and the rest of the playfield logic. It owns the IDLE/RUN/DEAD life cycle and drives `game_start` and `game_frozen` into the BCD score counter. After a collision it latches the final score into a BCD high-score register and flags a new record. It also derives a registered speed level from the live score for the obstacle generator.

---
 rtl/game_flow_ctrl.sv | 136 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: IDLE/RUN/LATCH/DEAD life cycle, score-counter control,
// BCD high-score capture and speed level derived from the live score.
module game_flow_ctrl #(
   parameter int          HOLD_TICKS = 30,
   parameter logic [15:0] SPD1_BCD   = 16'h0100,
   parameter logic [15:0] SPD2_BCD   = 16'h0300,
   parameter logic [15:0] SPD3_BCD   = 16'h0600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn,
   input  logic        collision,
   input  logic        game_tick,
   input  logic [15:0] score,
   output logic        game_start,
   output logic        game_frozen,
   output logic [1:0]  state,
   output logic [15:0] hi_score,
   output logic        new_hi,
   output logic [1:0]  speed
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] LATCH = 2'd2;
   localparam logic [1:0] DEAD  = 2'd3;

   localparam int             HW       = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_TICKS);

   logic [1:0]    state_q, state_d;
   logic          start_q, start_d;
   logic          frozen_q, frozen_d;
   logic [15:0]   hi_q, hi_d;
   logic          new_hi_q, new_hi_d;
   logic [1:0]    speed_q, speed_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          btn_q;
   logic          btn_rise;
   logic [1:0]    speed_lvl;

   assign btn_rise = btn & ~btn_q;

   // Packed BCD compares correctly as plain unsigned binary.
   always_comb begin
      speed_lvl = 2'd0;
      if (score >= SPD3_BCD)
         speed_lvl = 2'd3;
      else if (score >= SPD2_BCD)
         speed_lvl = 2'd2;
      else if (score >= SPD1_BCD)
         speed_lvl = 2'd1;
   end

   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      frozen_d = frozen_q;
      hi_d     = hi_q;
      new_hi_d = new_hi_q;
      speed_d  = speed_q;
      hold_d   = hold_q;
      case (state_q)
         IDLE: begin
            frozen_d = 1'b1;
            if (btn_rise) begin
               state_d  = RUN;
               start_d  = 1'b1;
               frozen_d = 1'b0;
               new_hi_d = 1'b0;
               speed_d  = 2'd0;
            end
         end
         RUN: begin
            frozen_d = 1'b0;
            if (collision) begin
               state_d  = LATCH;
               frozen_d = 1'b1;
            end else begin
               speed_d = speed_lvl;
            end
         end
         LATCH: begin
            if (score > hi_q) begin
               hi_d     = score;
               new_hi_d = 1'b1;
            end
            state_d = DEAD;
            hold_d  = '0;
         end
         default: begin
            frozen_d = 1'b1;
            if (game_tick && hold_q != HOLD_MAX)
               hold_d = hold_q + 1'b1;
            // Early presses are dropped; only a press after the hold counts.
            if (btn_rise && hold_q == HOLD_MAX) begin
               state_d  = RUN;
               start_d  = 1'b1;
               frozen_d = 1'b0;
               new_hi_d = 1'b0;
               speed_d  = 2'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         frozen_q <= 1'b1;
         hi_q     <= 16'h0000;
         new_hi_q <= 1'b0;
         speed_q  <= 2'd0;
         hold_q   <= '0;
         btn_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         frozen_q <= frozen_d;
         hi_q     <= hi_d;
         new_hi_q <= new_hi_d;
         speed_q  <= speed_d;
         hold_q   <= hold_d;
         btn_q    <= btn;
      end
   end

   assign game_start  = start_q;
   assign game_frozen = frozen_q;
   assign state       = state_q;
   assign hi_score    = hi_q;
   assign new_hi      = new_hi_q;
   assign speed       = speed_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short hold time in DEAD.
module tb_game_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn;
   logic        collision;
   logic        game_tick;
   logic [15:0] score;
   logic        game_start;
   logic        game_frozen;
   logic [1:0]  state;
   logic [15:0] hi_score;
   logic        new_hi;
   logic [1:0]  speed;

   integer checks = 0;
   integer errors = 0;

   game_flow_ctrl #(.HOLD_TICKS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .collision   (collision),
      .game_tick   (game_tick),
      .score       (score),
      .game_start  (game_start),
      .game_frozen (game_frozen),
      .state       (state),
      .hi_score    (hi_score),
      .new_hi      (new_hi),
      .speed       (speed)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      step();
   endtask

   // Wait out the DEAD hold and press start; score is cleared like the counter would be.
   task automatic restart();
      for (int i = 0; i < 3; i++) tick();
      score = 16'h0000;
      btn = 1'b1;
      step();
      btn = 1'b0;
   endtask

   task automatic crash(input logic [15:0] s);
      score = s;
      collision = 1'b1;
      step();
      collision = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = 1'b0; collision = 1'b0; game_tick = 1'b0; score = 16'h0000;
      step(); step();
      rst = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d exp 0", state); end
      checks++; if (game_frozen !== 1'b1) begin errors++; $display("[TB] FAIL reset_frozen got %b exp 1", game_frozen); end
      checks++; if (game_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %b exp 0", game_start); end
      checks++; if (hi_score !== 16'h0000) begin errors++; $display("[TB] FAIL reset_hi got %h exp 0000", hi_score); end
      checks++; if (new_hi !== 1'b0 || speed !== 2'd0) begin errors++; $display("[TB] FAIL reset_newhi_speed got %b/%0d exp 0/0", new_hi, speed); end
   endtask

   task automatic test_start_held();
      int pulses;
      btn = 1'b1;
      step();
      checks++; if (game_start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse got %b exp 1", game_start); end
      checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_state got %0d exp 1", state); end
      checks++; if (game_frozen !== 1'b0) begin errors++; $display("[TB] FAIL start_frozen got %b exp 0", game_frozen); end
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (game_start === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL held_btn_pulses got %0d exp 0", pulses); end
      btn = 1'b0;
      step();
   endtask

   task automatic test_first_crash();
      score = 16'h0042;
      collision = 1'b1;
      step();
      collision = 1'b0;
      checks++; if (state !== 2'd2 || game_frozen !== 1'b1) begin errors++; $display("[TB] FAIL crash_latch got st=%0d fr=%b exp st=2 fr=1", state, game_frozen); end
      checks++; if (hi_score !== 16'h0000) begin errors++; $display("[TB] FAIL crash_hi_early got %h exp 0000", hi_score); end
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL crash_dead got %0d exp 3", state); end
      checks++; if (hi_score !== 16'h0042 || new_hi !== 1'b1) begin errors++; $display("[TB] FAIL crash_hi got %h/%b exp 0042/1", hi_score, new_hi); end
   endtask

   task automatic test_hold();
      btn = 1'b1; step();
      checks++; if (state !== 2'd3 || game_start !== 1'b0) begin errors++; $display("[TB] FAIL hold_press0 got st=%0d gs=%b exp st=3 gs=0", state, game_start); end
      btn = 1'b0; step();
      tick(); tick();
      btn = 1'b1; step();
      checks++; if (state !== 2'd3 || game_start !== 1'b0) begin errors++; $display("[TB] FAIL hold_press2 got st=%0d gs=%b exp st=3 gs=0", state, game_start); end
      btn = 1'b0; step();
      checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL hold_not_queued got %0d exp 3", state); end
      tick();
      score = 16'h0000;
      btn = 1'b1; step();
      checks++; if (game_start !== 1'b1 || state !== 2'd1) begin errors++; $display("[TB] FAIL hold_press3 got gs=%b st=%0d exp gs=1 st=1", game_start, state); end
      checks++; if (new_hi !== 1'b0 || game_frozen !== 1'b0) begin errors++; $display("[TB] FAIL hold_newhi_clr got nh=%b fr=%b exp 0/0", new_hi, game_frozen); end
      btn = 1'b0; step();
      checks++; if (game_start !== 1'b0) begin errors++; $display("[TB] FAIL start_one_cycle got %b exp 0", game_start); end
   endtask

   task automatic test_hi_compare();
      crash(16'h0042);
      checks++; if (hi_score !== 16'h0042 || new_hi !== 1'b0) begin errors++; $display("[TB] FAIL equal_score got %h/%b exp 0042/0", hi_score, new_hi); end
      restart();
      step();
      crash(16'h0137);
      checks++; if (hi_score !== 16'h0137 || new_hi !== 1'b1) begin errors++; $display("[TB] FAIL higher_score got %h/%b exp 0137/1", hi_score, new_hi); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (state !== 2'd0 || hi_score !== 16'h0000) begin errors++; $display("[TB] FAIL midreset got st=%0d hi=%h exp 0/0000", state, hi_score); end
      checks++; if (game_frozen !== 1'b1 || game_start !== 1'b0 || new_hi !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got fr=%b gs=%b nh=%b exp 1/0/0", game_frozen, game_start, new_hi); end
   endtask

   task automatic test_speed();
      logic [15:0] sv [6];
      logic [1:0]  ev [6];
      sv = '{16'h0099, 16'h0100, 16'h0299, 16'h0300, 16'h0599, 16'h0600};
      ev = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
      btn = 1'b1; step(); btn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         score = sv[i];
         step();
         checks++; if (speed !== ev[i]) begin errors++; $display("[TB] FAIL speed_%h got %0d exp %0d", sv[i], speed, ev[i]); end
      end
      crash(16'h0600);
      checks++; if (speed !== 2'd3 || hi_score !== 16'h0600) begin errors++; $display("[TB] FAIL speed_hold got sp=%0d hi=%h exp 3/0600", speed, hi_score); end
      restart();
      checks++; if (speed !== 2'd0 || game_start !== 1'b1) begin errors++; $display("[TB] FAIL speed_clear got sp=%0d gs=%b exp 0/1", speed, game_start); end
      score = 16'h9999; step();
      score = 16'h0000; step();
      checks++; if (speed !== 2'd0) begin errors++; $display("[TB] FAIL speed_wrap got %0d exp 0", speed); end
   endtask

   initial begin
      test_reset();
      test_start_held();
      test_first_crash();
      test_hold();
      test_hi_compare();
      test_reset_mid();
      test_speed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
